// File: rtl/sram_word_ctrl_pkg.sv
// Shared types and sizes for the 32-bit word controller in front of a 16-bit asynchronous SRAM.
package sram_word_ctrl_pkg;

    localparam int unsigned SRAM_AW = 18;
    localparam int unsigned SRAM_DW = 16;
    localparam int unsigned PH_W    = 3;
    localparam int unsigned ADDR_W  = 19;
    localparam int unsigned WADDR_W = ADDR_W - 2;
    localparam int unsigned DATA_W  = 32;
    localparam int unsigned BE_W    = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LO   = 2'd1,
        ST_HI   = 2'd2,
        ST_ACK  = 2'd3
    } state_e;

    // Request captured at acceptance; held for the whole access.
    typedef struct packed {
        logic               wren;
        logic [WADDR_W-1:0] waddr;
        logic [BE_W-1:0]    bmask;
        logic [DATA_W-1:0]  wdata;
    } req_t;

endpackage

// File: rtl/sram_word_ctrl_if.sv
// Requester-side bundle for sram_word_ctrl: request, write payload, read data and completion.
interface sram_word_ctrl_if;
    import sram_word_ctrl_pkg::*;

    logic              req;
    logic              wren;
    logic [ADDR_W-1:0] addr;
    logic [BE_W-1:0]   bmask;
    logic [DATA_W-1:0] wdata;
    logic [DATA_W-1:0] rdata;
    logic              ack;
    logic              busy;

    modport master (output req, wren, addr, bmask, wdata, input rdata, ack, busy);
    modport slave  (input req, wren, addr, bmask, wdata, output rdata, ack, busy);

endinterface

// File: rtl/sram_word_ctrl.sv
// 32-bit word access over a 16-bit asynchronous SRAM as two halfword phases (LO then HI).
// Build option SRAM_WORD_CTRL_SKIP_EN: write phases with no enabled bytes take zero cycles.
module sram_word_ctrl
    import sram_word_ctrl_pkg::*;
#(
    parameter int unsigned WAIT_CYC = 1
) (
    input  logic               i_clk,
    input  logic               i_rstn,
    input  logic               i_req,
    input  logic               i_wren,
    input  logic [ADDR_W-1:0]  i_addr,
    input  logic [BE_W-1:0]    i_bmask,
    input  logic [DATA_W-1:0]  i_wdata,
    output logic [DATA_W-1:0]  o_rdata,
    output logic               o_ack,
    output logic               o_busy,
    output logic [SRAM_AW-1:0] o_sram_addr,
    inout  wire  [SRAM_DW-1:0] io_sram_dq,
    output logic               o_sram_ce_n,
    output logic               o_sram_oe_n,
    output logic               o_sram_we_n,
    output logic               o_sram_lb_n,
    output logic               o_sram_ub_n
);

    localparam logic [PH_W-1:0] PH_LAST = PH_W'(WAIT_CYC);

    state_e             state_q, state_d;
    logic [PH_W-1:0]    ph_q, ph_d;
    req_t               req_q, req_d;
    logic [SRAM_DW-1:0] rlo_q, rlo_d;
    logic [DATA_W-1:0]  rdata_q, rdata_d;
    logic               ack_q, ack_d;
    logic               busy_q, busy_d;
    logic [SRAM_AW-1:0] saddr_q, saddr_d;
    logic               ce_n_q, ce_n_d;
    logic               oe_n_q, oe_n_d;
    logic               we_n_q, we_n_d;
    logic               lb_n_q, lb_n_d;
    logic               ub_n_q, ub_n_d;
    logic               dq_oe_q, dq_oe_d;
    logic [SRAM_DW-1:0] dq_out_q, dq_out_d;
    logic               act_c, hi_c;
    logic               unused_addr_c;

    // Byte offset within the word has no meaning for word accesses.
    assign unused_addr_c = ^i_addr[1:0];

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            state_q  <= ST_IDLE;
            ph_q     <= '0;
            req_q    <= '0;
            rlo_q    <= '0;
            rdata_q  <= '0;
            ack_q    <= 1'b0;
            busy_q   <= 1'b0;
            saddr_q  <= '0;
            ce_n_q   <= 1'b1;
            oe_n_q   <= 1'b1;
            we_n_q   <= 1'b1;
            lb_n_q   <= 1'b1;
            ub_n_q   <= 1'b1;
            dq_oe_q  <= 1'b0;
            dq_out_q <= '0;
        end else begin
            state_q  <= state_d;
            ph_q     <= ph_d;
            req_q    <= req_d;
            rlo_q    <= rlo_d;
            rdata_q  <= rdata_d;
            ack_q    <= ack_d;
            busy_q   <= busy_d;
            saddr_q  <= saddr_d;
            ce_n_q   <= ce_n_d;
            oe_n_q   <= oe_n_d;
            we_n_q   <= we_n_d;
            lb_n_q   <= lb_n_d;
            ub_n_q   <= ub_n_d;
            dq_oe_q  <= dq_oe_d;
            dq_out_q <= dq_out_d;
        end
    end

    always_comb begin
        state_d = state_q;
        ph_d    = ph_q;
        req_d   = req_q;
        rlo_d   = rlo_q;
        rdata_d = rdata_q;

        unique case (state_q)
            ST_IDLE: begin
                if (i_req) begin
                    req_d.wren  = i_wren;
                    req_d.waddr = i_addr[ADDR_W-1:2];
                    req_d.bmask = i_bmask;
                    req_d.wdata = i_wdata;
                    ph_d        = '0;
`ifdef SRAM_WORD_CTRL_SKIP_EN
                    if (i_wren && (i_bmask[1:0] == 2'b00)) begin
                        state_d = (i_bmask[3:2] == 2'b00) ? ST_ACK : ST_HI;
                    end else begin
                        state_d = ST_LO;
                    end
`else
                    state_d = ST_LO;
`endif
                end
            end
            ST_LO: begin
                if (ph_q == PH_LAST) begin
                    ph_d = '0;
                    // Low half is staged so o_rdata only changes when the whole word is in.
                    if (!req_q.wren) begin
                        rlo_d = io_sram_dq;
                    end
`ifdef SRAM_WORD_CTRL_SKIP_EN
                    state_d = (req_q.wren && (req_q.bmask[3:2] == 2'b00)) ? ST_ACK : ST_HI;
`else
                    state_d = ST_HI;
`endif
                end else begin
                    ph_d = ph_q + PH_W'(1);
                end
            end
            ST_HI: begin
                if (ph_q == PH_LAST) begin
                    ph_d = '0;
                    if (!req_q.wren) begin
                        rdata_d = {io_sram_dq, rlo_q};
                    end
                    state_d = ST_ACK;
                end else begin
                    ph_d = ph_q + PH_W'(1);
                end
            end
            ST_ACK:  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase

        // Pins are decoded from the next state so every output leaves a flop.
        act_c    = (state_d == ST_LO) || (state_d == ST_HI);
        hi_c     = (state_d == ST_HI);
        ce_n_d   = 1'b1;
        oe_n_d   = 1'b1;
        we_n_d   = 1'b1;
        lb_n_d   = 1'b1;
        ub_n_d   = 1'b1;
        saddr_d  = '0;
        dq_oe_d  = 1'b0;
        dq_out_d = '0;
        if (act_c) begin
            ce_n_d  = 1'b0;
            saddr_d = {req_d.waddr, hi_c};
            if (req_d.wren) begin
                // Last phase cycle releases we_n while data is still driven (hold time).
                we_n_d  = (ph_d == PH_LAST);
                dq_oe_d = 1'b1;
                if (hi_c) begin
                    lb_n_d   = ~req_d.bmask[2];
                    ub_n_d   = ~req_d.bmask[3];
                    dq_out_d = req_d.wdata[31:16];
                end else begin
                    lb_n_d   = ~req_d.bmask[0];
                    ub_n_d   = ~req_d.bmask[1];
                    dq_out_d = req_d.wdata[15:0];
                end
            end else begin
                oe_n_d = 1'b0;
                lb_n_d = 1'b0;
                ub_n_d = 1'b0;
            end
        end
        ack_d  = (state_d == ST_ACK);
        busy_d = (state_d != ST_IDLE);
    end

    assign io_sram_dq  = dq_oe_q ? dq_out_q : {SRAM_DW{1'bz}};
    assign o_rdata     = rdata_q;
    assign o_ack       = ack_q;
    assign o_busy      = busy_q;
    assign o_sram_addr = saddr_q;
    assign o_sram_ce_n = ce_n_q;
    assign o_sram_oe_n = oe_n_q;
    assign o_sram_we_n = we_n_q;
    assign o_sram_lb_n = lb_n_q;
    assign o_sram_ub_n = ub_n_q;

endmodule

// File: tb/tb_sram_word_ctrl.sv
// Directed bench for sram_word_ctrl (WAIT_CYC=1) with a small byte-lane SRAM model.
// Expectations follow SRAM_WORD_CTRL_SKIP_EN when the bench is built with it.
module tb_sram_word_ctrl;

    localparam int MAXC = 12;

    typedef struct {
        logic        wren;
        logic [18:0] addr;
        logic [3:0]  bmask;
        logic [31:0] wdata;
        int          lat;
        logic [31:0] rdata;
        int          ce;
        int          we;
        int          oe;
        logic        lo_seen;
        logic        hi_seen;
        logic [1:0]  lo_bl;
        logic [1:0]  hi_bl;
        logic [15:0] lo_dq;
        logic [15:0] hi_dq;
    } vec_t;

    logic        clk;
    logic        rstn;
    logic [17:0] sram_addr;
    logic        ce_n, oe_n, we_n, lb_n, ub_n;
    tri1  [15:0] sram_dq;
    logic [15:0] mem [256];
    int          checks;
    int          errors;
    vec_t        vecs [7];

    sram_word_ctrl_if bus();

    sram_word_ctrl #(.WAIT_CYC(1)) dut (
        .i_clk       (clk),
        .i_rstn      (rstn),
        .i_req       (bus.req),
        .i_wren      (bus.wren),
        .i_addr      (bus.addr),
        .i_bmask     (bus.bmask),
        .i_wdata     (bus.wdata),
        .o_rdata     (bus.rdata),
        .o_ack       (bus.ack),
        .o_busy      (bus.busy),
        .o_sram_addr (sram_addr),
        .io_sram_dq  (sram_dq),
        .o_sram_ce_n (ce_n),
        .o_sram_oe_n (oe_n),
        .o_sram_we_n (we_n),
        .o_sram_lb_n (lb_n),
        .o_sram_ub_n (ub_n)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // SRAM model: drives on read, writes enabled byte lanes while we_n is low.
    assign sram_dq = (!ce_n && !oe_n && we_n) ? mem[sram_addr[7:0]] : 16'hzzzz;

    initial begin
        foreach (mem[i]) mem[i] = 16'h0000;
        forever begin
            @(posedge clk);
            if (!ce_n && !we_n) begin
                if (!lb_n) mem[sram_addr[7:0]][7:0]  = sram_dq[7:0];
                if (!ub_n) mem[sram_addr[7:0]][15:8] = sram_dq[15:8];
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", nm, act, exp);
        end
    endtask

    task automatic run_txn(input vec_t v, input string nm);
        int          lat, ack_cnt, busy_cnt, ce_lo, we_lo, oe_lo, idle_bad, rd_chg;
        logic        lo_seen, hi_seen;
        logic [1:0]  lo_bl, hi_bl;
        logic [15:0] lo_dq, hi_dq;
        logic [17:0] lo_a, hi_a;
        logic [31:0] rd0, rd_ack;
        lat = 0; ack_cnt = 0; busy_cnt = 0; ce_lo = 0; we_lo = 0; oe_lo = 0;
        idle_bad = 0; rd_chg = 0;
        lo_seen = 1'b0; hi_seen = 1'b0; lo_bl = '0; hi_bl = '0;
        lo_dq = '0; hi_dq = '0; lo_a = '0; hi_a = '0; rd_ack = '0;

        @(negedge clk);
        bus.req = 1'b1; bus.wren = v.wren; bus.addr = v.addr;
        bus.bmask = v.bmask; bus.wdata = v.wdata;
        rd0 = bus.rdata;
        @(posedge clk);
        #1;
        // Scrambled inputs must have no effect once the access is accepted.
        bus.req = 1'b0; bus.wren = ~v.wren; bus.addr = ~v.addr;
        bus.bmask = ~v.bmask; bus.wdata = ~v.wdata;

        for (int c = 1; c <= MAXC; c++) begin
            @(negedge clk);
            if (!ce_n) begin
                ce_lo++;
                if (!we_n) we_lo++;
                if (!oe_n) oe_lo++;
                if (!sram_addr[0] && !lo_seen) begin
                    lo_seen = 1'b1; lo_bl = {ub_n, lb_n}; lo_a = sram_addr; lo_dq = sram_dq;
                end else if (sram_addr[0] && !hi_seen) begin
                    hi_seen = 1'b1; hi_bl = {ub_n, lb_n}; hi_a = sram_addr; hi_dq = sram_dq;
                end
            end else if ({oe_n, we_n, lb_n, ub_n} != 4'hF || sram_addr != 18'h0 || sram_dq != 16'hFFFF) begin
                idle_bad++;
            end
            if (bus.busy) busy_cnt++;
            if (bus.ack) begin
                ack_cnt++;
                if (lat == 0) begin
                    lat = c;
                    rd_ack = bus.rdata;
                end
            end else if (lat == 0 && bus.rdata != rd0) begin
                rd_chg++;
            end
            if (lat != 0 && c > lat) break;
        end

        chk({nm, "_lat"}, lat, v.lat);
        chk({nm, "_ackcnt"}, ack_cnt, 1);
        chk({nm, "_busy"}, busy_cnt, v.lat);
        chk({nm, "_rdata"}, rd_ack, v.rdata);
        chk({nm, "_rdhold"}, rd_chg, 0);
        chk({nm, "_ce"}, ce_lo, v.ce);
        chk({nm, "_we"}, we_lo, v.we);
        chk({nm, "_oe"}, oe_lo, v.oe);
        chk({nm, "_idle"}, idle_bad, 0);
        chk({nm, "_loseen"}, 32'(lo_seen), 32'(v.lo_seen));
        chk({nm, "_hiseen"}, 32'(hi_seen), 32'(v.hi_seen));
        if (v.lo_seen && lo_seen) begin
            chk({nm, "_lobl"}, 32'(lo_bl), 32'(v.lo_bl));
            chk({nm, "_loaddr"}, 32'(lo_a), 32'({v.addr[18:2], 1'b0}));
            if (v.wren) chk({nm, "_lodq"}, 32'(lo_dq), 32'(v.lo_dq));
        end
        if (v.hi_seen && hi_seen) begin
            chk({nm, "_hibl"}, 32'(hi_bl), 32'(v.hi_bl));
            chk({nm, "_hiaddr"}, 32'(hi_a), 32'({v.addr[18:2], 1'b1}));
            if (v.wren) chk({nm, "_hidq"}, 32'(hi_dq), 32'(v.hi_dq));
        end
    endtask

    initial begin
        int a1, a2, rd_bad, ack_seen;
        logic b6, b7, b12;
        logic [31:0] r1, r2;
        checks = 0;
        errors = 0;

        //        wren  addr     mask   wdata         lat rdata         ce we oe lo    hi    lobl   hibl   lodq      hidq
        vecs[0] = '{1'b1, 19'h10, 4'hF, 32'hDEADBEEF, 5, 32'h00000000, 4, 2, 0, 1'b1, 1'b1, 2'b00, 2'b00, 16'hBEEF, 16'hDEAD};
        vecs[1] = '{1'b0, 19'h10, 4'hF, 32'h00000000, 5, 32'hDEADBEEF, 4, 0, 4, 1'b1, 1'b1, 2'b00, 2'b00, 16'h0000, 16'h0000};
`ifdef SRAM_WORD_CTRL_SKIP_EN
        vecs[2] = '{1'b1, 19'h10, 4'h4, 32'h00AA0000, 3, 32'hDEADBEEF, 2, 1, 0, 1'b0, 1'b1, 2'b11, 2'b10, 16'h0000, 16'h00AA};
        vecs[4] = '{1'b1, 19'h20, 4'h0, 32'h12345678, 1, 32'hDEAABEEF, 0, 0, 0, 1'b0, 1'b0, 2'b11, 2'b11, 16'h5678, 16'h1234};
        vecs[5] = '{1'b1, 19'h20, 4'h3, 32'hCAFEF00D, 3, 32'hDEAABEEF, 2, 1, 0, 1'b1, 1'b0, 2'b00, 2'b11, 16'hF00D, 16'hCAFE};
`else
        vecs[2] = '{1'b1, 19'h10, 4'h4, 32'h00AA0000, 5, 32'hDEADBEEF, 4, 2, 0, 1'b1, 1'b1, 2'b11, 2'b10, 16'h0000, 16'h00AA};
        vecs[4] = '{1'b1, 19'h20, 4'h0, 32'h12345678, 5, 32'hDEAABEEF, 4, 2, 0, 1'b1, 1'b1, 2'b11, 2'b11, 16'h5678, 16'h1234};
        vecs[5] = '{1'b1, 19'h20, 4'h3, 32'hCAFEF00D, 5, 32'hDEAABEEF, 4, 2, 0, 1'b1, 1'b1, 2'b00, 2'b11, 16'hF00D, 16'hCAFE};
`endif
        vecs[3] = '{1'b0, 19'h10, 4'hF, 32'h00000000, 5, 32'hDEAABEEF, 4, 0, 4, 1'b1, 1'b1, 2'b00, 2'b00, 16'h0000, 16'h0000};
        vecs[6] = '{1'b0, 19'h23, 4'h0, 32'hFFFFFFFF, 5, 32'h0000F00D, 4, 0, 4, 1'b1, 1'b1, 2'b00, 2'b00, 16'h0000, 16'h0000};

        // Reset state, with a request pending that must be ignored.
        rstn = 1'b0;
        bus.req = 1'b1; bus.wren = 1'b1; bus.addr = 19'h10; bus.bmask = 4'hF; bus.wdata = 32'h0;
        repeat (3) @(negedge clk);
        chk("rst_strobes", 32'({ce_n, oe_n, we_n, lb_n, ub_n}), 32'h1F);
        chk("rst_addr", 32'(sram_addr), 32'h0);
        chk("rst_dq", 32'(sram_dq), 32'hFFFF);
        chk("rst_ack", 32'(bus.ack), 32'h0);
        chk("rst_busy", 32'(bus.busy), 32'h0);
        chk("rst_rdata", bus.rdata, 32'h0);
        bus.req = 1'b0;
        rstn = 1'b1;
        repeat (2) @(negedge clk);

        for (int i = 0; i < 7; i++) begin
            run_txn(vecs[i], $sformatf("vec%0d", i));
        end

        // Abort a write in the second HI cycle.
        @(negedge clk);
        bus.req = 1'b1; bus.wren = 1'b1; bus.addr = 19'h40; bus.bmask = 4'hF; bus.wdata = 32'h11112222;
        @(posedge clk);
        #1;
        bus.req = 1'b0;
        repeat (4) @(negedge clk);
        chk("abort_pre_ce", 32'(ce_n), 32'h0);
        chk("abort_pre_dq", 32'(sram_dq), 32'h1111);
        rstn = 1'b0;
        #1;
        chk("abort_strobes", 32'({ce_n, oe_n, we_n, lb_n, ub_n}), 32'h1F);
        chk("abort_addr", 32'(sram_addr), 32'h0);
        chk("abort_dq", 32'(sram_dq), 32'hFFFF);
        chk("abort_busy", 32'(bus.busy), 32'h0);
        chk("abort_rdata", bus.rdata, 32'h0);
        ack_seen = 0;
        repeat (3) begin
            @(negedge clk);
            if (bus.ack) ack_seen++;
        end
        rstn = 1'b1;
        repeat (4) begin
            @(negedge clk);
            if (bus.ack || bus.busy) ack_seen++;
        end
        chk("abort_noack", ack_seen, 0);
        run_txn('{1'b0, 19'h40, 4'hF, 32'h0, 5, 32'h11112222, 4, 0, 4, 1'b1, 1'b1, 2'b00, 2'b00, 16'h0, 16'h0},
                "after_abort");

        // Back-to-back reads with i_req held across o_ack.
        @(negedge clk);
        bus.req = 1'b1; bus.wren = 1'b0; bus.addr = 19'h10; bus.bmask = 4'hF;
        @(posedge clk);
        #1;
        bus.addr = 19'h20;
        a1 = 0; a2 = 0; rd_bad = 0; b6 = 1'b1; b7 = 1'b0; b12 = 1'b1; r1 = '0; r2 = '0;
        for (int c = 1; c <= 14; c++) begin
            @(negedge clk);
            if (bus.ack) begin
                if (a1 == 0) begin
                    a1 = c; r1 = bus.rdata;
                end else if (a2 == 0) begin
                    a2 = c; r2 = bus.rdata;
                end
            end else if (a1 != 0 && a2 == 0 && bus.rdata != 32'hDEAABEEF) begin
                rd_bad++;
            end
            if (c == 6)  b6  = bus.busy;
            if (c == 7)  begin b7 = bus.busy; bus.req = 1'b0; end
            if (c == 12) b12 = bus.busy;
        end
        chk("b2b_ack1", a1, 5);
        chk("b2b_rdata1", r1, 32'hDEAABEEF);
        chk("b2b_idle_gap", 32'(b6), 32'h0);
        chk("b2b_accept2", 32'(b7), 32'h1);
        chk("b2b_ack2", a2, 11);
        chk("b2b_rdata2", r2, 32'h0000F00D);
        chk("b2b_rdhold", rd_bad, 0);
        chk("b2b_idle_end", 32'(b12), 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/sram_word_ctrl.md
SRAM_WORD_CTRL -- requirements
Module: sram_word_ctrl

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset; ports are named i_clk and i_rstn.
REQ-002 Parameter WAIT_CYC, default 1: extra SRAM access cycles per halfword phase (range 0..7).
REQ-003 Ports SHALL be, clock and reset first:
  i_clk  in  1  clock, rising edge
  i_rstn  in  1  async active-low reset
  i_req  in  1  access request, level
  i_wren  in  1  1 = write, 0 = read
  i_addr  in  19  byte address; bits [1:0] ignored
  i_bmask  in  4  write byte enables, bit n = byte n
  i_wdata  in  32  write data
  o_rdata  out  32  read data
  o_ack  out  1  one-cycle completion pulse
  o_busy  out  1  high in every state except IDLE
  o_sram_addr  out  18  SRAM halfword address
  io_sram_dq  inout  16  SRAM data bus
  o_sram_ce_n, o_sram_oe_n, o_sram_we_n, o_sram_lb_n, o_sram_ub_n  out  1 each  active-low SRAM strobes

Function
REQ-004 FSM states: IDLE, LO, HI, ACK.
REQ-005 IDLE: if i_req=1 at a rising edge, latch i_wren, i_addr[18:2], i_bmask, i_wdata; go to LO. Otherwise stay in IDLE.
REQ-006 i_req is sampled only in IDLE. Inputs are ignored in LO, HI and ACK.
REQ-007 LO and HI each last WAIT_CYC+1 cycles, counted by a 3-bit phase counter; LO then HI then ACK.
REQ-008 o_sram_addr SHALL be {addr[18:2],0} in LO and {addr[18:2],1} in HI; it is 0 in IDLE and ACK.
REQ-009 Strobes in LO/HI:
  - ce_n=0.
  - Read: oe_n=0, we_n=1, lb_n=ub_n=0.
  - Write: oe_n=1; we_n=0 for all phase cycles except the last, where we_n=1 to provide data hold.
  - Write byte lanes: lb_n/ub_n = ~bmask[0]/~bmask[1] in LO and ~bmask[2]/~bmask[3] in HI.
REQ-010 io_sram_dq SHALL be driven with wdata[15:0] in write-LO and wdata[31:16] in write-HI. It is high-Z in every other state and for all reads.
REQ-011 Read data is captured on the last cycle edge of each phase: LO into o_rdata[15:0], HI into o_rdata[31:16].
REQ-012 o_rdata SHALL hold its value until the next read completes; a write does not change o_rdata.
REQ-013 ACK lasts one cycle: o_ack=1, all strobes deasserted, then go to IDLE.
REQ-014 The requester SHALL present a new or deasserted i_req in the cycle after o_ack. A still-high i_req in IDLE starts a new access.
REQ-015 Latency with WAIT_CYC=W: o_ack rises 2(W+1)+1 cycles after the accepting edge; for W=1 this is 5 cycles.
REQ-016 Outside LO/HI, all strobes SHALL be 1 (ce_n, oe_n, we_n, lb_n, ub_n).

Reset
REQ-017 Asserting i_rstn low at any time, including mid-access, SHALL immediately force all of the following; the aborted access is dropped without o_ack:
  - state=IDLE, phase counter=0
  - all strobes=1, o_sram_addr=0, io_sram_dq=Z
  - o_ack=0, o_busy=0, o_rdata=0

Configuration
REQ-018 Macro SRAM_WORD_CTRL_SKIP_EN, when defined: a write phase whose two mask bits are both 0 SHALL be skipped with zero cycles. LO is skipped to HI, HI is skipped to ACK, and a write with mask 0000 goes IDLE→ACK so o_ack appears 1 cycle after acceptance.
REQ-019 Without SRAM_WORD_CTRL_SKIP_EN, both phases SHALL always execute with full timing. A phase with zero mask keeps lb_n=ub_n=1, so no bytes are written.

Structure
REQ-020 Package sram_word_ctrl_pkg SHALL hold the state enum, SRAM_AW=18, SRAM_DW=16 and the phase counter width.
REQ-021 No sub-module is required; the tristate is a single continuous assignment in the top.

Verification
REQ-022 Full write, W=1: i_req=1, i_wren=1, addr=0x00010, mask=1111, wdata=0xDEADBEEF. Expected:
  - LO addr=0x00008 carries 0xBEEF with we_n low 1 cycle.
  - HI addr=0x00009 carries 0xDEAD.
  - o_ack in cycle 5.
REQ-023 Read-back, W=1: the SRAM model returns 0xBEEF at 0x00008 and 0xDEAD at 0x00009. Expected: o_rdata=0xDEADBEEF at o_ack, dq never driven by the DUT, oe_n=0 for 4 cycles.
REQ-024 Byte write with mask 0100, wdata=0x00AA0000:
  - HI has lb_n=0, ub_n=1; LO has lb_n=ub_n=1.
  - With SKIP_EN, LO is absent and o_ack arrives in cycle 3.
REQ-025 Mask 0000 write:
  - With SKIP_EN, o_ack 1 cycle after acceptance and ce_n never low.
  - Without it, o_ack in cycle 5 with lb_n=ub_n=1.
REQ-026 Reset abort: drop i_rstn in the second cycle of HI. Expected: strobes=1 and dq=Z asynchronously, no o_ack, and after release a new read completes normally.
REQ-027 Back-to-back: i_req held high across o_ack with new address 0x00020. Expected: the second access is accepted in the IDLE cycle after ACK, and the first access's o_rdata is unchanged until the second o_ack.
